// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-issue core.
// Selects the next fetch address each cycle from the sequential, branch, jump
// or hold sources. Keeps every PC inside the instruction-memory window and
// holds at most one redirect that arrives while fetch is stalled. Also
// implements the boot cycle, halt/resume and a free-running fetch counter.
module pc_sequencer #(
    parameter int          IMEM_BYTES   = 64,
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        jump,
    input  logic [15:0] jump_target,
    input  logic        halt,
    input  logic        resume,
    output logic [15:0] pc_out,
    output logic        pc_valid,
    output logic [1:0]  state,
    output logic        misalign_err,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Window mask; IMEM_BYTES is a power of two so modulo is a bitwise AND.
    localparam logic [15:0] ADDR_MASK   = 16'(IMEM_BYTES - 1);
    // Same mask with bit0 cleared so accepted targets are always halfword aligned.
    localparam logic [15:0] TARGET_MASK = ADDR_MASK & 16'hFFFE;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [15:0] pend_target_q, pend_target_d;
    logic        misalign_q, misalign_d;
    logic [15:0] count_q, count_d;

    logic        redirect;
    logic [15:0] raw_target;
    logic [15:0] accepted_target;
    logic [15:0] seq_pc;

    // Redirect source selection: jump wins over a same-cycle taken branch.
    assign redirect        = jump | branch_taken;
    assign raw_target      = jump ? jump_target : branch_target;
    assign accepted_target = raw_target & TARGET_MASK;
    assign seq_pc          = (pc_q + 16'd2) & ADDR_MASK;

    // State register and all datapath registers, with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 16'h0000;
            misalign_q    <= 1'b0;
            count_q       <= 16'h0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            misalign_q    <= misalign_d;
            count_q       <= count_d;
        end
    end

    // Next-state and next-PC selection by state and per-cycle priority.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a signal unassigned and infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        misalign_d    = 1'b0;
        count_d       = count_q;

        case (state_q)
            ST_BOOT: begin
                // One idle cycle, then fetch starts at the reset vector.
                state_d = ST_RUN;
                pc_d    = RESET_VECTOR;
            end

            ST_RUN: begin
                if (halt) begin
                    state_d      = ST_HALT;
                    pend_valid_d = 1'b0;
                end else if (stall) begin
                    // Hold the PC; keep only the oldest redirect seen while stalled.
                    if (redirect && !pend_valid_q) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = accepted_target;
                        misalign_d    = raw_target[0];
                    end
                end else begin
                    count_d = count_q + 16'd1;
                    if (pend_valid_q) begin
                        // Buffered redirect beats anything arriving this cycle.
                        pc_d         = pend_target_q;
                        pend_valid_d = 1'b0;
                    end else if (redirect) begin
                        pc_d       = accepted_target;
                        misalign_d = raw_target[0];
                    end else begin
                        pc_d = seq_pc;
                    end
                end
            end

            ST_HALT: begin
                // halt held high keeps us here even if resume is also asserted.
                if (!halt && resume) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign pc_out       = pc_q;
    assign pc_valid     = (state_q == ST_RUN);
    assign state        = state_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// traffic. A behavioural model predicts the outputs after every clock edge and
// queues them; an independent monitor compares them with the DUT.
module tb_pc_sequencer;

    localparam int          IMEM         = 64;
    localparam logic [15:0] RV           = 16'h0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        jump = 1'b0;
    logic [15:0] jump_target = 16'h0000;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic [15:0] pc_out;
    logic        pc_valid;
    logic [1:0]  state;
    logic        misalign_err;
    logic [15:0] fetch_count;

    pc_sequencer #(.IMEM_BYTES(IMEM), .RESET_VECTOR(RV)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt          (halt),
        .resume        (resume),
        .pc_out        (pc_out),
        .pc_valid      (pc_valid),
        .state         (state),
        .misalign_err  (misalign_err),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        bit valid;
        int st;
        bit mis;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model: mode 0=boot, 1=run, 2=halt; pending redirects in a queue.
    int   m_mode = 0;
    int   m_pc   = 0;
    bit   m_mis  = 0;
    int   m_cnt  = 0;
    int   m_pend[$];

    function automatic int accept(input int t);
        return ((t % IMEM) / 2) * 2;
    endfunction

    task automatic model_step(input bit r, input bit s, input bit b, input int bt,
                              input bit j, input int jt, input bit h, input bit rs);
        bit redir;
        int tgt;
        redir = j || b;
        tgt   = j ? jt : bt;
        m_mis = 0;
        if (r) begin
            m_mode = 0;
            m_pc   = int'(RV);
            m_cnt  = 0;
            m_pend.delete();
        end else if (m_mode == 0) begin
            m_mode = 1;
            m_pc   = int'(RV);
        end else if (m_mode == 1) begin
            if (h) begin
                m_mode = 2;
                m_pend.delete();
            end else if (s) begin
                if (redir && m_pend.size() == 0) begin
                    m_pend.push_back(accept(tgt));
                    m_mis = (tgt % 2) == 1;
                end
            end else begin
                m_cnt = (m_cnt + 1) % 65536;
                if (m_pend.size() > 0) begin
                    m_pc = m_pend.pop_front();
                end else if (redir) begin
                    m_pc  = accept(tgt);
                    m_mis = (tgt % 2) == 1;
                end else begin
                    m_pc = (m_pc + 2) % IMEM;
                end
            end
        end else begin
            if (!h && rs) m_mode = 1;
        end
    endtask

    // Apply one cycle of inputs and queue the outputs expected after that edge.
    task automatic drive(input bit r, input bit s, input bit b, input logic [15:0] bt,
                         input bit j, input logic [15:0] jt, input bit h, input bit rs);
        exp_t e;
        @(negedge clk);
        #1;
        reset = r; stall = s; branch_taken = b; branch_target = bt;
        jump = j; jump_target = jt; halt = h; resume = rs;
        model_step(r, s, b, int'(bt), j, int'(jt), h, rs);
        e.pc    = m_pc;
        e.valid = (m_mode == 1);
        e.st    = m_mode;
        e.mis   = m_mis;
        e.cnt   = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
    endtask

    task automatic idle_until_pc(input int v);
        bit found;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_mode == 1 && m_pc == v) found = 1;
            else drive(0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
        end
        if (!found) begin
            $display("FAIL reach_pc: model never reached pc %0d, required within 200 cycles", v);
            n_bad++;
        end
    endtask

    // Monitor: whenever an expectation is queued, compare it against the DUT.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (pc_out !== 16'(e.pc) || pc_valid !== e.valid || state !== 2'(e.st) ||
                    misalign_err !== e.mis || fetch_count !== 16'(e.cnt)) begin
                    n_bad++;
                    $display("FAIL outputs cyc%0d: got pc=%0d valid=%0b state=%0d mis=%0b cnt=%0d, required pc=%0d valid=%0b state=%0d mis=%0b cnt=%0d",
                             cyc, pc_out, pc_valid, state, misalign_err, fetch_count,
                             e.pc, e.valid, e.st, e.mis, e.cnt);
                end
            end
        end
    end

    initial begin
        // 1. Reset, boot and free-run across the window wrap.
        drive(1, 0, 0, 16'h0, 0, 16'h0, 0, 0);
        drive(1, 0, 0, 16'h0, 0, 16'h0, 0, 0);
        idle(35);

        // 2. Jump and taken branch together: jump wins.
        idle_until_pc(10);
        drive(0, 0, 1, 16'd20, 1, 16'd40, 0, 0);
        idle(2);

        // 3. Redirects during a three-cycle stall: the oldest is kept.
        idle_until_pc(6);
        drive(0, 1, 1, 16'd30, 0, 16'h0, 0, 0);
        drive(0, 1, 0, 16'h0, 1, 16'd50, 0, 0);
        drive(0, 1, 0, 16'h0, 0, 16'h0, 0, 0);
        idle(3);

        // 4. Odd, out-of-window jump target.
        drive(0, 0, 0, 16'h0, 1, 16'h0047, 0, 0);
        idle(3);

        // 5. Halt, ignored jumps, resume, then halt+resume together.
        idle_until_pc(12);
        drive(0, 0, 0, 16'h0, 0, 16'h0, 1, 0);
        drive(0, 0, 0, 16'h0, 1, 16'd40, 0, 0);
        drive(0, 1, 1, 16'd8, 1, 16'd40, 0, 0);
        drive(0, 0, 0, 16'h0, 0, 16'h0, 0, 1);
        idle(2);
        drive(0, 0, 0, 16'h0, 0, 16'h0, 1, 0);
        drive(0, 0, 0, 16'h0, 0, 16'h0, 1, 1);
        drive(0, 0, 0, 16'h0, 0, 16'h0, 1, 1);
        drive(0, 0, 0, 16'h0, 0, 16'h0, 0, 1);
        idle(2);

        // 6. Reset while stalled with a pending target.
        idle_until_pc(20);
        drive(0, 1, 1, 16'd44, 0, 16'h0, 0, 0);
        drive(1, 1, 0, 16'h0, 0, 16'h0, 0, 0);
        drive(0, 1, 0, 16'h0, 0, 16'h0, 0, 0);
        drive(0, 1, 0, 16'h0, 0, 16'h0, 0, 0);
        idle(4);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            bit r, s, b, j, h, rs;
            logic [15:0] bt, jt;
            r  = ($urandom_range(0, 149) == 0);
            s  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 3) == 0);
            j  = ($urandom_range(0, 5) == 0);
            h  = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 2) == 0);
            bt = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, IMEM - 1)) : 16'($urandom);
            jt = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, IMEM - 1)) : 16'($urandom);
            drive(r, s, b, bt, j, jt, h, rs);
        end

        // Let the monitor consume the last expectation, then confirm the queue drained.
        @(negedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the 16-bit program counter and sequences instruction fetch for the single-issue core. Each cycle it selects the next PC from these sources: sequential (+2 bytes), branch target, jump target or hold. It wraps every PC into the instruction-memory window and buffers a redirect that arrives during a stall. It also implements boot and halt/resume, and counts fetches. It sits between the decode/execute redirect logic and the instruction-memory address port.

Parameters:
IMEM_BYTES, 64, instruction-memory size in bytes; power of two, at least 4; every PC is taken modulo IMEM_BYTES.
RESET_VECTOR, 16'h0000, PC loaded on reset; must be even and below IMEM_BYTES.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
stall  input  1  hold the PC this cycle (hazard/imem wait).
branch_taken  input  1  conditional branch resolved taken.
branch_target  input  16  branch destination byte address.
jump  input  1  unconditional jump.
jump_target  input  16  jump destination byte address.
halt  input  1  halt request from decode.
resume  input  1  leave HALT.
pc_out  output  16  current fetch address (registered).
pc_valid  output  1  pc_out is a valid fetch this cycle.
state  output  2  BOOT=0, RUN=1, HALT=2.
misalign_err  output  1  one-cycle pulse: an odd target was accepted.
fetch_count  output  16  number of valid fetch cycles since reset; wraps.

Behaviour:
- All state updates on the rising edge of clk. Reset is sampled only on a clock edge.
- Reset values: pc_out=RESET_VECTOR, pc_valid=0, state=BOOT, misalign_err=0, fetch_count=0, pending-redirect valid=0.
- Reset asserted mid-operation discards the pending redirect and the HALT state on that edge.
- Wrap rule: seq = (pc_out+2) & (IMEM_BYTES-1). A target is accepted as (target & (IMEM_BYTES-1)) with bit0 forced to 0.
- If an accepted target had bit0=1, misalign_err=1 for exactly the cycle after acceptance; otherwise misalign_err=0.
- Effective redirect each cycle: jump takes priority over branch_taken. A target is "accepted" when it is loaded into pc_out or captured as pending.
- BOOT: lasts one cycle and ignores all inputs. Next state is RUN with pc_out=RESET_VECTOR and pc_valid=1 (no advance).
- RUN, priority per cycle:
  1. halt=1: go to HALT; pc_out holds; pc_valid=0 from the next cycle; the pending redirect is cleared; other inputs are ignored.
  2. stall=1: pc_out holds. If a redirect is present and nothing is pending, capture its target as pending. If something is already pending, keep it (oldest wins) and drop the new redirect.
  3. stall=0 with pending valid: pc_out<=pending target and pending is cleared. Any same-cycle redirect is dropped.
  4. stall=0 with a redirect: pc_out<=target.
  5. Otherwise: pc_out<=seq. Example: 62 wraps to 0 when IMEM_BYTES=64.
- pc_valid=1 throughout RUN, including stall cycles. fetch_count increments on every RUN cycle where stall=0 and halt=0.
- HALT: pc_out holds and pc_valid=0. stall, branch_taken and jump are ignored. resume=1 moves to RUN on the next edge with pc_out unchanged; fetching restarts at the held PC. halt has priority over resume when both are asserted.
- Latency: a redirect presented in cycle N appears on pc_out in cycle N+1 (unstalled). A pending redirect appears in the cycle after stall falls.
- state encoding 3 is unused; if ever reached, the next state is BOOT.

Test Plan:
1. Reset, then free-run, IMEM_BYTES=64: BOOT for 1 cycle (pc_valid=0). Then pc_out=0,2,4,...,62,0. fetch_count=32 after 32 RUN cycles.
2. At pc_out=10, assert jump=1 (target 40) and branch_taken=1 (target 20) together -> next pc_out=40. misalign_err stays 0.
3. stall=1 for 3 cycles at pc_out=6. Branch to 30 in stall cycle 1, jump to 50 in stall cycle 2. pc_out holds 6 throughout. After stall falls, next pc_out=30, then 32. fetch_count does not increment during the stall.
4. Jump target 16'h0047 -> pc_out=6 next cycle and misalign_err=1 for exactly one cycle.
5. halt at pc_out=12: pc_out holds 12 and pc_valid=0. Jumps during HALT are ignored. resume -> pc_out=12 with pc_valid=1, then 14. halt+resume asserted together keeps the block in HALT.
6. Assert reset while stalled with a pending target of 44: next edge gives BOOT, pc_out=RESET_VECTOR, pending cleared. After stall falls, the sequence restarts from RESET_VECTOR, not 44.
